// File: rtl/timer_core_multi.sv
// Machine-timer core: prescaled mtime counter plus N compare channels,
// each in level or periodic (auto-advancing, sticky pending) mode.
module timer_core_multi #(
  parameter int N     = 2,
  parameter int CntW  = 64,
  parameter int PreW  = 12,
  parameter int StepW = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              active_i,
  input  logic [PreW-1:0]   prescaler_i,
  input  logic [StepW-1:0]  step_i,
  input  logic              mtime_we_i,
  input  logic [CntW-1:0]   mtime_wdata_i,
  output logic [CntW-1:0]   mtime_o,
  output logic              tick_o,
  input  logic [N-1:0]      cmp_we_i,
  input  logic [CntW-1:0]   cmp_wdata_i,
  input  logic [N*CntW-1:0] period_i,
  input  logic [N-1:0]      periodic_i,
  output logic [N*CntW-1:0] cmp_o,
  input  logic [N-1:0]      intr_clr_i,
  output logic [N-1:0]      intr_o
);

  logic [PreW-1:0] tick_cnt_r;
  logic [CntW-1:0] mtime_r;
  logic [CntW-1:0] step_ext_s;
  logic            tick_s;

  // A prescaler lowered below the running count ticks at once and restarts.
  assign tick_s     = active_i & (tick_cnt_r >= prescaler_i);
  assign step_ext_s = {{(CntW-StepW){1'b0}}, step_i};
  assign tick_o     = tick_s;
  assign mtime_o    = mtime_r;

  // Prescaler counter: cleared while inactive and on every tick.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt_r <= {PreW{1'b0}};
    end else if (!active_i || tick_s) begin
      tick_cnt_r <= {PreW{1'b0}};
    end else begin
      tick_cnt_r <= tick_cnt_r + PreW'(1);
    end
  end

  // mtime: software load beats the tick increment; wraps silently.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_r <= {CntW{1'b0}};
    end else if (mtime_we_i) begin
      mtime_r <= mtime_wdata_i;
    end else if (tick_s) begin
      mtime_r <= mtime_r + step_ext_s;
    end else begin
      mtime_r <= mtime_r;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [CntW-1:0] cmp_r;
    logic [CntW-1:0] period_s;
    logic            hit_s;
    logic            pending_r;
    logic            pending_next_s;
    logic            intr_r;

    assign period_s = period_i[g*CntW +: CntW];
    assign hit_s    = (mtime_r >= cmp_r);
    assign cmp_o[g*CntW +: CntW] = cmp_r;
    assign intr_o[g] = intr_r;

    // Sticky pending: a new hit wins over a coincident clear; level mode keeps it empty.
    always_comb begin
      pending_next_s = 1'b0;
      if (!periodic_i[g]) begin
        pending_next_s = 1'b0;
      end else if (active_i && hit_s && !cmp_we_i[g]) begin
        pending_next_s = 1'b1;
      end else if (intr_clr_i[g]) begin
        pending_next_s = 1'b0;
      end else begin
        pending_next_s = pending_r;
      end
    end

    // Compare register: write beats the periodic advance, at most one period per cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cmp_r <= {CntW{1'b1}};
      end else if (cmp_we_i[g]) begin
        cmp_r <= cmp_wdata_i;
      end else if (periodic_i[g] && active_i && hit_s) begin
        cmp_r <= cmp_r + period_s;
      end else begin
        cmp_r <= cmp_r;
      end
    end

    // Pending flag and registered interrupt output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pending_r <= 1'b0;
        intr_r    <= 1'b0;
      end else begin
        pending_r <= pending_next_s;
        if (periodic_i[g]) begin
          intr_r <= pending_next_s & active_i;
        end else begin
          intr_r <= active_i & hit_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_core_multi.sv
// Directed self-checking bench for timer_core_multi (N=2, 64-bit counters).
module tb_timer_core_multi;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         active_i;
  logic [11:0]  prescaler_i;
  logic [7:0]   step_i;
  logic         mtime_we_i;
  logic [63:0]  mtime_wdata_i;
  logic [63:0]  mtime_o;
  logic         tick_o;
  logic [1:0]   cmp_we_i;
  logic [63:0]  cmp_wdata_i;
  logic [127:0] period_i;
  logic [1:0]   periodic_i;
  logic [127:0] cmp_o;
  logic [1:0]   intr_clr_i;
  logic [1:0]   intr_o;

  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  timer_core_multi #(.N(2), .CntW(64), .PreW(12), .StepW(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .active_i(active_i), .prescaler_i(prescaler_i),
    .step_i(step_i), .mtime_we_i(mtime_we_i), .mtime_wdata_i(mtime_wdata_i),
    .mtime_o(mtime_o), .tick_o(tick_o), .cmp_we_i(cmp_we_i), .cmp_wdata_i(cmp_wdata_i),
    .period_i(period_i), .periodic_i(periodic_i), .cmp_o(cmp_o),
    .intr_clr_i(intr_clr_i), .intr_o(intr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0; active_i = 1'b0; prescaler_i = 12'd0; step_i = 8'd0;
    mtime_we_i = 1'b0; mtime_wdata_i = 64'd0; cmp_we_i = 2'b00; cmp_wdata_i = 64'd0;
    period_i = 128'd0; periodic_i = 2'b00; intr_clr_i = 2'b00;
    cyc(); cyc();
    chk("rst_mtime", mtime_o, 64'd0);
    chk("rst_tick", {63'd0, tick_o}, 64'd0);
    chk("rst_cmp0", cmp_o[63:0], ONES);
    chk("rst_cmp1", cmp_o[127:64], ONES);
    chk("rst_intr", {62'd0, intr_o}, 64'd0);
    rst_ni = 1'b1;
    cyc();

    // 1: prescaler 3 -> tick every 4th cycle
    prescaler_i = 12'd3; step_i = 8'd1; active_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("t1_tick", {63'd0, tick_o}, ((i % 4) == 3) ? 64'd1 : 64'd0);
      chk("t1_mtime", mtime_o, 64'(i / 4));
    end
    cyc(); cyc();
    active_i = 1'b0;
    cyc(); cyc(); cyc();
    chk("t1_frz_mtime", mtime_o, 64'd4);
    chk("t1_frz_tick", {63'd0, tick_o}, 64'd0);
    active_i = 1'b1;
    cyc(); cyc();
    chk("t1_restart_notick", {63'd0, tick_o}, 64'd0);
    cyc();
    chk("t1_restart_tick", {63'd0, tick_o}, 64'd1);
    cyc();
    chk("t1_restart_mtime", mtime_o, 64'd5);

    // 2: level ch0, cmp=10
    prescaler_i = 12'd0;
    mtime_we_i = 1'b1; mtime_wdata_i = 64'd5; cmp_we_i = 2'b01; cmp_wdata_i = 64'd10;
    cyc();
    mtime_we_i = 1'b0; cmp_we_i = 2'b00;
    chk("t2_load", mtime_o, 64'd5);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("t2_m10", mtime_o, 64'd10);
    chk("t2_intr_lo", {63'd0, intr_o[0]}, 64'd0);
    cyc();
    chk("t2_intr_hi", {63'd0, intr_o[0]}, 64'd1);
    cmp_we_i = 2'b01; cmp_wdata_i = 64'd100;
    cyc();
    cmp_we_i = 2'b00;
    chk("t2_cmp100", cmp_o[63:0], 64'd100);
    chk("t2_intr_hold", {63'd0, intr_o[0]}, 64'd1);
    cyc();
    chk("t2_intr_drop", {63'd0, intr_o[0]}, 64'd0);

    // 3: periodic ch1, cmp=8, period=5
    mtime_we_i = 1'b1; mtime_wdata_i = 64'd0; cmp_we_i = 2'b10; cmp_wdata_i = 64'd8;
    period_i[127:64] = 64'd5; periodic_i = 2'b10;
    cyc();
    mtime_we_i = 1'b0; cmp_we_i = 2'b00;
    for (int i = 0; i < 8; i++) cyc();
    chk("t3_m8", mtime_o, 64'd8);
    chk("t3_intr_lo", {63'd0, intr_o[1]}, 64'd0);
    cyc();
    chk("t3_cmp13", cmp_o[127:64], 64'd13);
    chk("t3_intr_hi", {63'd0, intr_o[1]}, 64'd1);
    cyc(); cyc(); cyc(); cyc();
    chk("t3_sticky", {63'd0, intr_o[1]}, 64'd1);
    cyc();
    chk("t3_cmp18", cmp_o[127:64], 64'd18);
    intr_clr_i = 2'b10;
    cyc();
    intr_clr_i = 2'b00;
    chk("t3_clr", {63'd0, intr_o[1]}, 64'd0);
    cyc(); cyc(); cyc();
    chk("t3_m18", mtime_o, 64'd18);
    intr_clr_i = 2'b10;
    cyc();
    intr_clr_i = 2'b00;
    chk("t3_setwins", {63'd0, intr_o[1]}, 64'd1);
    chk("t3_cmp23", cmp_o[127:64], 64'd23);
    periodic_i = 2'b00;
    cyc();
    chk("t3_level_off", {63'd0, intr_o[1]}, 64'd0);

    // 4: load near all-ones coincident with a tick, step 4 wraps
    step_i = 8'd4; mtime_we_i = 1'b1; mtime_wdata_i = ONES - 64'd1;
    cmp_we_i = 2'b01; cmp_wdata_i = ONES;
    chk("t4_tick_at_load", {63'd0, tick_o}, 64'd1);
    cyc();
    mtime_we_i = 1'b0; cmp_we_i = 2'b00;
    chk("t4_loaded", mtime_o, ONES - 64'd1);
    cyc();
    chk("t4_wrap", mtime_o, 64'd2);
    chk("t4_nohit", {63'd0, intr_o[0]}, 64'd0);
    mtime_we_i = 1'b1; mtime_wdata_i = ONES;
    cyc();
    mtime_we_i = 1'b0;
    cyc();
    chk("t4_wrap3", mtime_o, 64'd3);
    chk("t4_hit_top", {63'd0, intr_o[0]}, 64'd1);
    cyc();
    chk("t4_drop", {63'd0, intr_o[0]}, 64'd0);

    // 5: catch-up after mtime jump, one period per cycle
    step_i = 8'd0; mtime_we_i = 1'b1; mtime_wdata_i = 64'd0;
    cmp_we_i = 2'b10; cmp_wdata_i = 64'd10; period_i[127:64] = 64'd10; periodic_i = 2'b10;
    cyc();
    cmp_we_i = 2'b00; mtime_wdata_i = 64'd50;
    chk("t5_intr_init", {63'd0, intr_o[1]}, 64'd0);
    cyc();
    mtime_we_i = 1'b0;
    chk("t5_m50", mtime_o, 64'd50);
    for (int i = 2; i <= 6; i++) begin
      cyc();
      chk("t5_cmp", cmp_o[127:64], 64'(i * 10));
      chk("t5_pend", {63'd0, intr_o[1]}, 64'd1);
    end
    cyc();
    chk("t5_cmp_settle", cmp_o[127:64], 64'd60);
    active_i = 1'b0;
    cyc();
    chk("t5_masked", {63'd0, intr_o[1]}, 64'd0);
    active_i = 1'b1;
    cyc();
    chk("t5_retained", {63'd0, intr_o[1]}, 64'd1);

    // 6: async reset mid-count, then first tick after prescaler+1 cycles
    prescaler_i = 12'd2; step_i = 8'd1;
    cyc();
    chk("t6_pre_intr", {63'd0, intr_o[1]}, 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_mtime", mtime_o, 64'd0);
    chk("t6_rst_intr", {62'd0, intr_o}, 64'd0);
    chk("t6_rst_cmp0", cmp_o[63:0], ONES);
    chk("t6_rst_cmp1", cmp_o[127:64], ONES);
    chk("t6_rst_tick", {63'd0, tick_o}, 64'd0);
    cyc(); cyc();
    rst_ni = 1'b1;
    cyc();
    chk("t6_c1_tick", {63'd0, tick_o}, 64'd0);
    cyc();
    chk("t6_c2_tick", {63'd0, tick_o}, 64'd1);
    cyc();
    chk("t6_c3_mtime", mtime_o, 64'd1);
    chk("t6_c3_tick", {63'd0, tick_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
